// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: arbitrated access controller for data-memory port 1.
// Shares one word-wide port between the CPU MEM stage and the debug/loader
// requester (round-robin). It performs RISC-V load extension and does
// read-modify-write for byte and halfword stores. It also rejects
// out-of-range addresses and undefined widths.
// Optional feature macro: DM_CTRL_MISALIGN_TRAP_EN. When it is defined,
// misaligned halfword and word accesses are flagged as errors. When it is
// undefined, the low address bits are ignored and the access is aligned.
module dm_access_ctrl #(
  parameter logic [15:0] ADDR_LIMIT = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [15:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic [15:0] dm_add,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata,
  input  logic        dm_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  state_t      state_q, state_d;
  owner_t      last_q, last_d;
  owner_t      owner_q, owner_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;   // store data, later the merged RMW word
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Selected requester and its request fields
  logic        sel_valid;
  owner_t      sel_owner;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_illegal;
  logic        f3_ok;
  logic        misalign;

  logic [15:0] word_addr;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign word_addr = {addr_q[15:2], 2'b00};

  // Round-robin pick: on a tie, serve whoever was not served last
  always_comb begin
    sel_valid = cpu_req | dbg_req;
    sel_owner = OWN_CPU;
    if (cpu_req && dbg_req) begin
      sel_owner = (last_q == OWN_DBG) ? OWN_CPU : OWN_DBG;
    end else if (dbg_req) begin
      sel_owner = OWN_DBG;
    end
    if (sel_owner == OWN_DBG) begin
      req_we     = dbg_we;
      req_funct3 = 3'b010;
      req_addr   = dbg_addr;
      req_wdata  = dbg_wdata;
    end else begin
      req_we     = cpu_we;
      req_funct3 = cpu_funct3;
      req_addr   = cpu_addr;
      req_wdata  = cpu_wdata;
    end
  end

  // Legality of the selected request: width code, range, optional alignment
  always_comb begin
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~req_we;  // no unsigned stores
      default:                f3_ok = 1'b0;
    endcase
`ifdef DM_CTRL_MISALIGN_TRAP_EN
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_illegal = ~f3_ok | (req_addr >= ADDR_LIMIT) | misalign;
  end

  // Lane extraction and extension for loads, lane merge for sub-word stores
  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   rd_byte = dm_rdata[7:0];
      2'b01:   rd_byte = dm_rdata[15:8];
      2'b10:   rd_byte = dm_rdata[23:16];
      default: rd_byte = dm_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    unique case (funct3_q)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_val = {24'h0, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = dm_rdata;
    endcase

    merged = dm_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      unique case (addr_q[1:0])
        2'b00:   merged[7:0]   = wdata_q[7:0];
        2'b01:   merged[15:8]  = wdata_q[7:0];
        2'b10:   merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Next-state, capture and output decode
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    cpu_done  = 1'b0;
    dbg_done  = 1'b0;
    cpu_rdata = '0;
    dbg_rdata = '0;
    cpu_err   = 1'b0;
    dbg_err   = 1'b0;
    dm_add    = '0;
    dm_wdata  = '0;
    dm_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // gnt is combinational from req, so it is forced low during reset
        if (sel_valid && !rst) begin
          cpu_gnt  = (sel_owner == OWN_CPU);
          dbg_gnt  = (sel_owner == OWN_DBG);
          owner_d  = sel_owner;
          last_d   = sel_owner;
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = req_illegal;
          if (req_illegal) begin
            state_d = S_RESP;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        dm_add = word_addr;
        err_d  = err_q | dm_error;
        if (we_q) begin
          wdata_d = merged;
          state_d = S_WR;
        end else begin
          rdata_d = load_val;
          state_d = S_RESP;
        end
      end
      S_WR: begin
        dm_add   = word_addr;
        dm_wdata = wdata_q;
        dm_we    = 1'b1;
        err_d    = err_q | dm_error;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (owner_q == OWN_CPU) begin
          cpu_done  = 1'b1;
          cpu_rdata = rdata_q;
          cpu_err   = err_q;
        end else begin
          dbg_done  = 1'b1;
          dbg_rdata = rdata_q;
          dbg_err   = err_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= OWN_DBG;
      owner_q  <= OWN_CPU;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: directed accesses push expected
// responses and writes; a negedge monitor pops and compares them.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_funct3 = '0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt, dbg_done, dbg_err;
  logic [31:0] dbg_rdata;
  logic [15:0] dm_add;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;
  logic        dm_error = 1'b0;

  dm_access_ctrl #(.ADDR_LIMIT(16'h3000)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .dm_add(dm_add), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .dm_rdata(dm_rdata), .dm_error(dm_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Word-wide memory model with combinational read
  logic [31:0] mem [0:4095];
  assign dm_rdata = mem[dm_add[13:2]];
  always @(posedge clk) if (dm_we) mem[dm_add[13:2]] <= dm_wdata;

  typedef struct {
    logic        owner;   // 0 = CPU, 1 = DBG
    logic [31:0] rdata;
    logic        err;
    int          lat;     // cycles from gnt cycle to done cycle
  } exp_t;
  typedef struct {
    logic [15:0] add;
    logic [31:0] data;
  } wexp_t;

  exp_t  sbq[$];
  wexp_t wq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    g_cpu   = 0;
  int    g_dbg   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {9'b0, cpu_gnt, cpu_done, cpu_rdata, cpu_err, dbg_gnt, dbg_done,
            dbg_rdata, dbg_err, dm_add, dm_wdata, dm_we};
  endfunction

  // Monitor: compare writes and completions against the queues
  always @(negedge clk) begin
    exp_t  e;
    wexp_t w;
    if (cpu_gnt) g_cpu = cyc;
    if (dbg_gnt) g_dbg = cyc;
    if (dm_we) begin
      if (wq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: got add=%h data=%h required none", dm_add, dm_wdata);
      end else begin
        w = wq.pop_front();
        chk("write_addr", dm_add, w.add);
        chk("write_data", dm_wdata, w.data);
      end
    end
    if (cpu_done || dbg_done) begin
      if (cpu_done && dbg_done) begin
        n_tests++; n_fail++;
        $display("FAIL double_done: got both done high required one");
      end
      if (sbq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: got done cpu=%b dbg=%b required none", cpu_done, dbg_done);
      end else begin
        e = sbq.pop_front();
        chk("done_owner", dbg_done, e.owner);
        chk("rdata", dbg_done ? dbg_rdata : cpu_rdata, e.rdata);
        chk("err", dbg_done ? dbg_err : cpu_err, e.err);
        chk("latency", cyc - (dbg_done ? g_dbg : g_cpu), e.lat);
      end
    end
  end

  task automatic access(input logic own, input logic we, input logic [2:0] f3,
                        input logic [15:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input logic exp_wr, input logic [15:0] wadd, input logic [31:0] wword);
    exp_t  e;
    wexp_t w;
    bit    seen;
    seen    = 1'b0;
    e.owner = own; e.rdata = exp_rd; e.err = exp_err; e.lat = lat;
    sbq.push_back(e);
    if (exp_wr) begin
      w.add = wadd; w.data = wword;
      wq.push_back(w);
    end
    @(posedge clk); #1;
    if (!own) begin
      cpu_we = we; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    end else begin
      dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if ((!own && cpu_done) || (own && dbg_done)) seen = 1'b1;
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL access_timeout: got no done for addr %h required done", a);
      sbq.delete();
      wq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test required finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[16'h0010 >> 2] = 32'h8180_7F01;
    mem[16'h0020 >> 2] = 32'h1122_3344;
    mem[16'h0004 >> 2] = 32'h0BAD_F00D;

    // Reset: outputs zero even with a request pending
    cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 128'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Tie right after reset: CPU first, then strict alternation
    begin
      exp_t e;
      e.rdata = 32'h8180_7F01; e.err = 1'b0; e.lat = 2;
      e.owner = 1'b0; sbq.push_back(e);
      e.owner = 1'b1; e.rdata = 32'h1122_3344; sbq.push_back(e);
      e.owner = 1'b0; e.rdata = 32'h8180_7F01; sbq.push_back(e);
      e.owner = 1'b1; e.rdata = 32'h1122_3344; sbq.push_back(e);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 16'h0010; cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_addr = 16'h0020; dbg_req = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (cpu_done || dbg_done) n++;
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("arb_done_count", n, 4);

    // Loads with extension
    access(0, 0, 3'b000, 16'h0012, 0, 32'hFFFF_FF80, 0, 2, 0, 0, 0);
    access(0, 0, 3'b100, 16'h0012, 0, 32'h0000_0080, 0, 2, 0, 0, 0);
    access(0, 0, 3'b001, 16'h0012, 0, 32'hFFFF_8180, 0, 2, 0, 0, 0);
    access(0, 0, 3'b101, 16'h0010, 0, 32'h0000_7F01, 0, 2, 0, 0, 0);
    access(0, 0, 3'b001, 16'h0010, 0, 32'h0000_7F01, 0, 2, 0, 0, 0);
    access(0, 0, 3'b000, 16'h0011, 0, 32'h0000_007F, 0, 2, 0, 0, 0);

    // Sub-word stores via read-modify-write
    access(0, 1, 3'b000, 16'h0021, 32'hFFFF_FFAB, 0, 0, 3, 1, 16'h0020, 32'h1122_AB44);
    access(0, 0, 3'b010, 16'h0020, 0, 32'h1122_AB44, 0, 2, 0, 0, 0);
    access(0, 1, 3'b001, 16'h0022, 32'h0000_BEEF, 0, 0, 3, 1, 16'h0020, 32'hBEEF_AB44);
    access(1, 0, 3'b010, 16'h0020, 0, 32'hBEEF_AB44, 0, 2, 0, 0, 0);

    // Range and width errors, plus last legal byte address
    access(0, 0, 3'b010, 16'h3004, 0, 32'h0, 1, 1, 0, 0, 0);
    access(0, 1, 3'b010, 16'h3000, 32'h1234_5678, 32'h0, 1, 1, 0, 0, 0);
    access(0, 0, 3'b000, 16'h2FFF, 0, 32'h0, 0, 2, 0, 0, 0);
    access(0, 0, 3'b011, 16'h0010, 0, 32'h0, 1, 1, 0, 0, 0);
    access(0, 1, 3'b100, 16'h0010, 32'h55, 32'h0, 1, 1, 0, 0, 0);

    // Misaligned word store
`ifdef DM_CTRL_MISALIGN_TRAP_EN
    access(0, 1, 3'b010, 16'h0006, 32'h5566_7788, 32'h0, 1, 1, 0, 0, 0);
    access(0, 0, 3'b010, 16'h0004, 0, 32'h0BAD_F00D, 0, 2, 0, 0, 0);
`else
    access(0, 1, 3'b010, 16'h0006, 32'h5566_7788, 32'h0, 0, 2, 1, 16'h0004, 32'h5566_7788);
    access(0, 0, 3'b010, 16'h0004, 0, 32'h5566_7788, 0, 2, 0, 0, 0);
`endif

    // Memory-side error on a debug store still writes but flags err
    dm_error = 1'b1;
    access(1, 1, 3'b010, 16'h0030, 32'hCAFE_F00D, 32'h0, 1, 2, 1, 16'h0030, 32'hCAFE_F00D);
    dm_error = 1'b0;
    access(1, 0, 3'b010, 16'h0030, 0, 32'hCAFE_F00D, 0, 2, 0, 0, 0);

    // Reset in the WR cycle of a halfword store: no commit
    begin
      wexp_t w;
      w.add = 16'h0020; w.data = 32'h1234_AB44;
      wq.push_back(w);
    end
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_funct3 = 3'b001; cpu_addr = 16'h0022; cpu_wdata = 32'h0000_1234; cpu_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (cpu_gnt) seen = 1'b1;
    end
    chk("sh_granted", seen, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("wr_cycle_we", dm_we, 1'b1);
    #1 rst = 1'b1;
    #1 chk("reset_mid_wr", all_outs(), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0;
    chk("mem_unchanged", mem[16'h0020 >> 2], 32'hBEEF_AB44);
    access(0, 0, 3'b010, 16'h0020, 0, 32'hBEEF_AB44, 0, 2, 0, 0, 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
